// File: rtl/fp_norm_pkg.sv
// Shared constants and request record for the post-add normalization arbiter.
package fp_norm_pkg;
  localparam int SIG_W   = 23;
  localparam int EXP_W   = 8;
  localparam int SHIFT_W = 5;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             g;
  } norm_req_t;
endpackage

// File: rtl/fp_norm_lzc.sv
// Combinational leading-zero count of a 23-bit significand, plus all-zero detect.
module fp_norm_lzc
  import fp_norm_pkg::*;
(
  input  logic [SIG_W-1:0]   sig,
  output logic [SHIFT_W-1:0] lz_count,
  output logic               is_zero
);

  // The first set bit from the MSB fixes the count; is_zero doubles as "not yet found".
  always_comb begin
    lz_count = '0;
    is_zero  = 1'b1;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (is_zero && sig[i]) begin
        lz_count = SHIFT_W'(SIG_W - 1 - i);
        is_zero  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_norm_arbiter.sv
// Round-robin arbiter sharing one normalization shifter between FP adder lanes.
// Define FP_NORM_ARB_PERF_EN to add saturating busy/stall performance counters.
module fp_norm_arbiter
  import fp_norm_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_LANES-1:0]       req_valid_i,
  output logic [NUM_LANES-1:0]       req_ready_o,
  input  logic [NUM_LANES*SIG_W-1:0] req_sig_i,
  input  logic [NUM_LANES-1:0]       req_g_i,
  input  logic [NUM_LANES*EXP_W-1:0] req_exp_i,
  input  logic [NUM_LANES-1:0]       req_sign_i,
  output logic [SIG_W-1:0]           sh_significand_o,
  output logic                       sh_g_o,
  output logic [SHIFT_W-1:0]         sh_shift_o,
  input  logic [SIG_W-1:0]           sh_result_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [LANE_W-1:0]          res_lane_o,
  output logic [SIG_W-1:0]           res_sig_o,
  output logic [EXP_W-1:0]           res_exp_o,
  output logic                       res_sign_o,
  output logic                       res_zero_o,
  output logic                       res_uflow_o
`ifdef FP_NORM_ARB_PERF_EN
  ,
  output logic [31:0]                perf_busy_o,
  output logic [31:0]                perf_stall_o
`endif
);

  norm_req_t           lane_req [NUM_LANES];
  norm_req_t           sel_req;
  norm_req_t           s1_req;
  logic [LANE_W-1:0]   rr_ptr;
  logic [LANE_W-1:0]   grant_lane;
  logic [LANE_W-1:0]   s1_lane;
  logic                grant_found;
  logic                grant_en;
  logic                accept;
  logic                advance;
  logic                s1_v;
  logic                s2_v;
  logic [SHIFT_W-1:0]  lz_count;
  logic                lz_zero;
  logic [SHIFT_W-1:0]  sel_shift;
  logic                sel_zero;
  logic [SHIFT_W-1:0]  s1_shift;
  logic                s1_zero;
  logic [EXP_W:0]      exp_diff;
  logic                uflow;
  logic                flush;

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_req[l].sign = req_sign_i[l];
      lane_req[l].exp  = req_exp_i[l*EXP_W +: EXP_W];
      lane_req[l].sig  = req_sig_i[l*SIG_W +: SIG_W];
      lane_req[l].g    = req_g_i[l];
    end
  end

  // Scan lanes starting at rr_ptr; the first valid one wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_lane  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_LANES;
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_lane  = LANE_W'(idx);
      end
    end
  end

  // Reset also masks the grant so every output reads zero while rst_i is high.
  assign advance     = !s2_v || res_ready_i;
  assign grant_en    = !rst_i && (!s1_v || advance);
  assign accept      = grant_en && grant_found;
  assign req_ready_o = accept ? (NUM_LANES'(1) << grant_lane) : '0;
  assign sel_req     = lane_req[grant_lane];

  fp_norm_lzc u_lzc (
    .sig      (sel_req.sig),
    .lz_count (lz_count),
    .is_zero  (lz_zero)
  );

  // An all-zero significand with only the guard set needs the full 23-bit shift.
  assign sel_shift = lz_zero ? (sel_req.g ? SHIFT_W'(SIG_W) : '0) : lz_count;
  assign sel_zero  = lz_zero && !sel_req.g;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_v     <= 1'b0;
      s1_req   <= '0;
      s1_shift <= '0;
      s1_zero  <= 1'b0;
      s1_lane  <= '0;
      rr_ptr   <= '0;
    end else begin
      if (grant_en) begin
        s1_v <= grant_found;
      end
      if (accept) begin
        s1_req   <= sel_req;
        s1_shift <= sel_shift;
        s1_zero  <= sel_zero;
        s1_lane  <= grant_lane;
        rr_ptr   <= (grant_lane == LANE_W'(NUM_LANES - 1)) ? '0 : grant_lane + 1'b1;
      end
    end
  end

  assign sh_significand_o = s1_v ? s1_req.sig : '0;
  assign sh_g_o           = s1_v && s1_req.g;
  assign sh_shift_o       = s1_v ? s1_shift : '0;

  // A borrow means shift > exp; a zero difference from a nonzero shift is also flushed.
  assign exp_diff = {1'b0, s1_req.exp} - {{(EXP_W + 1 - SHIFT_W){1'b0}}, s1_shift};
  assign uflow    = !s1_zero && (exp_diff[EXP_W] ||
                    (exp_diff[EXP_W-1:0] == '0 && s1_shift != '0));
  assign flush    = s1_zero || uflow;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_v        <= 1'b0;
      res_lane_o  <= '0;
      res_sig_o   <= '0;
      res_exp_o   <= '0;
      res_sign_o  <= 1'b0;
      res_zero_o  <= 1'b0;
      res_uflow_o <= 1'b0;
    end else if (advance) begin
      s2_v <= s1_v;
      if (s1_v) begin
        res_lane_o  <= s1_lane;
        res_sig_o   <= flush ? '0 : sh_result_i;
        res_exp_o   <= flush ? '0 : exp_diff[EXP_W-1:0];
        res_sign_o  <= s1_req.sign;
        res_zero_o  <= s1_zero;
        res_uflow_o <= uflow;
      end
    end
  end

  assign res_valid_o = s2_v;

`ifdef FP_NORM_ARB_PERF_EN
  logic any_valid;
  assign any_valid = |req_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_busy_o  <= '0;
      perf_stall_o <= '0;
    end else begin
      if (any_valid && perf_busy_o != '1) begin
        perf_busy_o <= perf_busy_o + 32'd1;
      end
      if (any_valid && req_ready_o == '0 && perf_stall_o != '1) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_norm_arbiter.sv
// Directed self-checking bench for fp_norm_arbiter with a behavioural shared shifter.
module tb_fp_norm_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [3:0]   req_valid_i;
  logic [3:0]   req_ready_o;
  logic [91:0]  req_sig_i;
  logic [3:0]   req_g_i;
  logic [31:0]  req_exp_i;
  logic [3:0]   req_sign_i;
  logic [22:0]  sh_significand_o;
  logic         sh_g_o;
  logic [4:0]   sh_shift_o;
  logic [22:0]  sh_result_i;
  logic         res_valid_o;
  logic         res_ready_i;
  logic [1:0]   res_lane_o;
  logic [22:0]  res_sig_o;
  logic [7:0]   res_exp_o;
  logic         res_sign_o;
  logic         res_zero_o;
  logic         res_uflow_o;
`ifdef FP_NORM_ARB_PERF_EN
  logic [31:0]  perf_busy_o;
  logic [31:0]  perf_stall_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fp_norm_arbiter #(.NUM_LANES(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_sig_i        (req_sig_i),
    .req_g_i          (req_g_i),
    .req_exp_i        (req_exp_i),
    .req_sign_i       (req_sign_i),
    .sh_significand_o (sh_significand_o),
    .sh_g_o           (sh_g_o),
    .sh_shift_o       (sh_shift_o),
    .sh_result_i      (sh_result_i),
    .res_valid_o      (res_valid_o),
    .res_ready_i      (res_ready_i),
    .res_lane_o       (res_lane_o),
    .res_sig_o        (res_sig_o),
    .res_exp_o        (res_exp_o),
    .res_sign_o       (res_sign_o),
    .res_zero_o       (res_zero_o),
    .res_uflow_o      (res_uflow_o)
`ifdef FP_NORM_ARB_PERF_EN
    ,
    .perf_busy_o      (perf_busy_o),
    .perf_stall_o     (perf_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Shared shifter: {sig, g} shifted left, top 23 bits returned.
  logic [23:0] shifted;
  always_comb begin
    shifted     = {sh_significand_o, sh_g_o} << sh_shift_o;
    sh_result_i = shifted[23:1];
  end

  task automatic set_lane(input int l, input logic [22:0] sig, input logic g,
                          input logic [7:0] e, input logic s);
    req_sig_i[l*23 +: 23] = sig;
    req_g_i[l]            = g;
    req_exp_i[l*8 +: 8]   = e;
    req_sign_i[l]         = s;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    req_valid_i = '0;
    res_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // Presents one request and returns at the window after it is accepted (entry in s1).
  task automatic present(input int l, input logic [22:0] sig, input logic g,
                         input logic [7:0] e, input logic s, output bit ok);
    ok = 1'b0;
    set_lane(l, sig, g, e, s);
    req_valid_i[l] = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (req_ready_o[l]) ok = 1'b1;
      @(posedge clk_i);
      #1;
    end
    req_valid_i[l] = 1'b0;
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    req_valid_i = 4'b1111;
    res_ready_i = 1'b1;
    req_sig_i   = {4{23'h123456}};
    req_g_i     = '0;
    req_exp_i   = {4{8'd50}};
    req_sign_i  = '0;
    #3;
    n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready_o); end
    n_checks++; if (res_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", res_valid_o); end
    n_checks++; if ({sh_significand_o, sh_g_o, sh_shift_o} !== 29'd0) begin n_fail++; $display("[TB] FAIL reset_sh: got %h/%b/%0d expected 0", sh_significand_o, sh_g_o, sh_shift_o); end
    n_checks++; if ({res_lane_o, res_sig_o, res_exp_o, res_sign_o, res_zero_o, res_uflow_o} !== 36'd0) begin n_fail++; $display("[TB] FAIL reset_res: got lane %0d sig %h exp %0d expected all 0", res_lane_o, res_sig_o, res_exp_o); end
    do_reset();
  endtask

  task automatic test_single_lane();
    bit ok;
    present(0, 23'h100000, 1'b0, 8'd100, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL single_grant: got no grant expected grant of lane 0"); end
    n_checks++; if (sh_shift_o !== 5'd2) begin n_fail++; $display("[TB] FAIL single_shift: got %0d expected 2", sh_shift_o); end
    n_checks++; if (sh_significand_o !== 23'h100000) begin n_fail++; $display("[TB] FAIL single_shsig: got %h expected 100000", sh_significand_o); end
    @(posedge clk_i); #1;
    n_checks++; if (res_valid_o !== 1'b1 || res_lane_o !== 2'd0) begin n_fail++; $display("[TB] FAIL single_valid: got v=%b lane=%0d expected v=1 lane=0", res_valid_o, res_lane_o); end
    n_checks++; if (res_sig_o !== 23'h400000 || res_exp_o !== 8'd98) begin n_fail++; $display("[TB] FAIL single_res: got %h/%0d expected 400000/98", res_sig_o, res_exp_o); end
    @(posedge clk_i); #1;
    n_checks++; if (res_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL single_drain: got %b expected 0", res_valid_o); end
  endtask

  task automatic test_round_robin();
    logic [22:0] base;
    int          lane;
    base = 23'h400000;
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, base >> i, 1'b0, 8'd50, i[0]);
    req_valid_i = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) req_valid_i = '0;
      #1;
      if (c < 5) begin
        n_checks++; if (req_ready_o !== (4'b0001 << (c % 4))) begin n_fail++; $display("[TB] FAIL rr_grant c=%0d: got %b expected %b", c, req_ready_o, 4'b0001 << (c % 4)); end
      end
      if (c >= 2 && c < 7) begin
        lane = (c - 2) % 4;
        n_checks++; if (res_valid_o !== 1'b1 || res_lane_o !== 2'(lane)) begin n_fail++; $display("[TB] FAIL rr_order c=%0d: got v=%b lane=%0d expected v=1 lane=%0d", c, res_valid_o, res_lane_o, lane); end
        n_checks++; if (res_sig_o !== 23'h400000 || res_exp_o !== 8'(50 - lane)) begin n_fail++; $display("[TB] FAIL rr_data c=%0d: got %h/%0d expected 400000/%0d", c, res_sig_o, res_exp_o, 50 - lane); end
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_special_shifts();
    bit ok;
    present(2, 23'h000000, 1'b1, 8'd30, 1'b1, ok);
    n_checks++; if (!ok || sh_shift_o !== 5'd23) begin n_fail++; $display("[TB] FAIL guard_shift: got ok=%b shift=%0d expected 23", ok, sh_shift_o); end
    @(posedge clk_i); #1;
    n_checks++; if (res_sig_o !== 23'h400000 || res_exp_o !== 8'd7 || res_lane_o !== 2'd2 || res_sign_o !== 1'b1) begin n_fail++; $display("[TB] FAIL guard_res: got %h/%0d lane %0d sign %b expected 400000/7 lane 2 sign 1", res_sig_o, res_exp_o, res_lane_o, res_sign_o); end
    n_checks++; if (res_zero_o !== 1'b0 || res_uflow_o !== 1'b0) begin n_fail++; $display("[TB] FAIL guard_flags: got z=%b u=%b expected 0/0", res_zero_o, res_uflow_o); end
    present(3, 23'h000000, 1'b0, 8'd77, 1'b0, ok);
    n_checks++; if (!ok || sh_shift_o !== 5'd0) begin n_fail++; $display("[TB] FAIL zero_shift: got ok=%b shift=%0d expected 0", ok, sh_shift_o); end
    @(posedge clk_i); #1;
    n_checks++; if (res_zero_o !== 1'b1 || res_uflow_o !== 1'b0 || res_sig_o !== 23'd0 || res_exp_o !== 8'd0) begin n_fail++; $display("[TB] FAIL zero_res: got z=%b u=%b %h/%0d expected z=1 u=0 0/0", res_zero_o, res_uflow_o, res_sig_o, res_exp_o); end
  endtask

  task automatic test_underflow();
    bit ok;
    present(1, 23'h000001, 1'b0, 8'd10, 1'b0, ok);
    n_checks++; if (!ok || sh_shift_o !== 5'd22) begin n_fail++; $display("[TB] FAIL uflow_shift: got ok=%b shift=%0d expected 22", ok, sh_shift_o); end
    @(posedge clk_i); #1;
    n_checks++; if (res_uflow_o !== 1'b1 || res_sig_o !== 23'd0 || res_exp_o !== 8'd0 || res_zero_o !== 1'b0) begin n_fail++; $display("[TB] FAIL uflow_res: got u=%b z=%b %h/%0d expected u=1 z=0 0/0", res_uflow_o, res_zero_o, res_sig_o, res_exp_o); end
    present(0, 23'h000100, 1'b0, 8'd14, 1'b0, ok);
    @(posedge clk_i); #1;
    n_checks++; if (!ok || res_uflow_o !== 1'b1 || res_exp_o !== 8'd0 || res_sig_o !== 23'd0) begin n_fail++; $display("[TB] FAIL uflow_equal: got ok=%b u=%b %h/%0d expected u=1 0/0", ok, res_uflow_o, res_sig_o, res_exp_o); end
    present(0, 23'h000100, 1'b0, 8'd15, 1'b0, ok);
    @(posedge clk_i); #1;
    n_checks++; if (!ok || res_uflow_o !== 1'b0 || res_exp_o !== 8'd1 || res_sig_o !== 23'h400000) begin n_fail++; $display("[TB] FAIL uflow_edge: got ok=%b u=%b %h/%0d expected u=0 400000/1", ok, res_uflow_o, res_sig_o, res_exp_o); end
  endtask

  task automatic test_back_pressure();
    logic [22:0] sigs [4];
    logic [7:0]  exps [4];
    logic [7:0]  want_exp [4];
    logic [1:0]  want_lane [4];
    logic [1:0]  got_lane [8];
    logic [7:0]  got_exp [8];
    logic [3:0]  rdy;
    int          k1, k2, n_got;
    sigs      = '{23'h200000, 23'h080000, 23'h400000, 23'h000400};
    exps      = '{8'd40, 8'd41, 8'd42, 8'd43};
    want_exp  = '{8'd39, 8'd38, 8'd42, 8'd31};
    want_lane = '{2'd1, 2'd2, 2'd1, 2'd2};
    k1 = 0; k2 = 0; n_got = 0;
    do_reset();
    for (int w = 0; w < 14; w++) begin
      res_ready_i = (w >= 5);
      req_valid_i = '0;
      if (k1 < 2) begin set_lane(1, sigs[2*k1], 1'b0, exps[2*k1], 1'b0); req_valid_i[1] = 1'b1; end
      if (k2 < 2) begin set_lane(2, sigs[1+2*k2], 1'b0, exps[1+2*k2], 1'b1); req_valid_i[2] = 1'b1; end
      #1;
      rdy = req_ready_o;
      if (w == 0) begin
        n_checks++; if (rdy !== 4'b0010) begin n_fail++; $display("[TB] FAIL bp_first: got %b expected 0010", rdy); end
      end
      if (w == 1) begin
        n_checks++; if (rdy !== 4'b0100) begin n_fail++; $display("[TB] FAIL bp_second: got %b expected 0100", rdy); end
      end
      if (w >= 2 && w <= 4) begin
        n_checks++; if (rdy !== 4'b0000) begin n_fail++; $display("[TB] FAIL bp_stall w=%0d: got %b expected 0000", w, rdy); end
        n_checks++; if (res_valid_o !== 1'b1 || res_lane_o !== 2'd1 || res_exp_o !== 8'd39 || res_sig_o !== 23'h400000) begin n_fail++; $display("[TB] FAIL bp_hold w=%0d: got v=%b lane %0d %h/%0d expected v=1 lane 1 400000/39", w, res_valid_o, res_lane_o, res_sig_o, res_exp_o); end
      end
      if (res_valid_o && res_ready_i && n_got < 8) begin
        got_lane[n_got] = res_lane_o;
        got_exp[n_got]  = res_exp_o;
        n_got++;
      end
      @(posedge clk_i); #1;
      if (rdy[1]) k1++;
      if (rdy[2]) k2++;
    end
    n_checks++; if (n_got !== 4) begin n_fail++; $display("[TB] FAIL bp_count: got %0d results expected 4", n_got); end
    for (int i = 0; i < 4 && i < n_got; i++) begin
      n_checks++; if (got_lane[i] !== want_lane[i] || got_exp[i] !== want_exp[i]) begin n_fail++; $display("[TB] FAIL bp_seq %0d: got lane %0d exp %0d expected lane %0d exp %0d", i, got_lane[i], got_exp[i], want_lane[i], want_exp[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    res_ready_i = 1'b0;
    set_lane(1, 23'h200000, 1'b0, 8'd40, 1'b0);
    set_lane(2, 23'h080000, 1'b0, 8'd41, 1'b0);
    set_lane(3, 23'h100000, 1'b0, 8'd60, 1'b0);
    req_valid_i = 4'b0110;
    @(posedge clk_i); #1;
    req_valid_i = 4'b0100;
    @(posedge clk_i); #1;
    req_valid_i = 4'b0000;
    n_checks++; if (res_valid_o !== 1'b1 || sh_shift_o !== 5'd3) begin n_fail++; $display("[TB] FAIL mid_full: got v=%b shift=%0d expected v=1 shift=3", res_valid_o, sh_shift_o); end
    rst_i       = 1'b1;
    req_valid_i = 4'b1010;
    #1;
    n_checks++; if (res_valid_o !== 1'b0 || req_ready_o !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_rst_out: got v=%b ready=%b expected 0/0000", res_valid_o, req_ready_o); end
    n_checks++; if (sh_shift_o !== 5'd0 || sh_significand_o !== 23'd0 || res_lane_o !== 2'd0 || res_exp_o !== 8'd0 || res_sig_o !== 23'd0) begin n_fail++; $display("[TB] FAIL mid_rst_data: got shift %0d shsig %h lane %0d %h/%0d expected 0", sh_shift_o, sh_significand_o, res_lane_o, res_sig_o, res_exp_o); end
    @(posedge clk_i); #1;
    rst_i       = 1'b0;
    req_valid_i = '0;
    res_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      n_checks++; if (res_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_stale c=%0d: got %b expected 0", c, res_valid_o); end
    end
    req_valid_i = 4'b1010;
    #1;
    n_checks++; if (req_ready_o !== 4'b0010) begin n_fail++; $display("[TB] FAIL mid_rrptr: got %b expected 0010", req_ready_o); end
    @(posedge clk_i); #1;
    req_valid_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting fp_norm_arbiter bench");
    test_reset();
    test_single_lane();
    test_round_robin();
    test_special_shifts();
    test_underflow();
    test_back_pressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
